compare_seq: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for the microcontroller core, replacing the single-cycle combinational compare path for wide operands.
- Scans operands MSB-chunk first, one chunk per cycle, and terminates early on the first differing chunk.
- Supports signed and unsigned modes, and evaluates the six ALU relations.
- Uses valid/ready handshakes on both sides, so the ALU or a branch unit can stall on it.

---
 rtl/compare_seq_pkg.sv | 38 +++
 rtl/compare_seq_chunk.sv | 20 ++
 rtl/compare_seq.sv | 154 +++++++++++++++
 tb/tb_compare_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/compare_seq_pkg.sv
// Shared definitions for the multi-cycle magnitude comparator: relation codes,
// FSM state encoding and the flag-to-relation mapping.
package compare_seq_pkg;

   localparam logic [2:0] ALU_SMALLER  = 3'd1;
   localparam logic [2:0] ALU_EQUAL    = 3'd2;
   localparam logic [2:0] ALU_LARGER   = 3'd3;
   localparam logic [2:0] ALU_NSMALLER = 3'd4;
   localparam logic [2:0] ALU_NEQUAL   = 3'd5;
   localparam logic [2:0] ALU_NLARGER  = 3'd6;

   typedef enum logic [1:0] {
      CMP_IDLE = 2'd0,
      CMP_SCAN = 2'd1,
      CMP_DONE = 2'd2
   } cmp_state_e;

   // Codes 0 and 7 are reserved.
   function automatic logic relation_illegal(input logic [2:0] rel);
      return (rel == 3'd0) || (rel == 3'd7);
   endfunction

   function automatic logic relation_result(input logic [2:0] rel, input logic lt,
                                            input logic eq, input logic gt);
      logic res;
      case (rel)
         ALU_SMALLER:  res = lt;
         ALU_EQUAL:    res = eq;
         ALU_LARGER:   res = gt;
         ALU_NSMALLER: res = !lt;
         ALU_NEQUAL:   res = !eq;
         ALU_NLARGER:  res = !gt;
         default:      res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/compare_seq_chunk.sv
// Combinational comparator for one operand chunk; signed_en selects
// two's-complement ordering.
module compare_chunk #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_en,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   always_comb begin
      eq = (a == b);
      lt = signed_en ? ($signed(a) < $signed(b)) : (a < b);
      gt = !lt && !eq;
   end

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: scans operands MSB chunk first, stops at the
// first differing chunk, and reports one of six relations plus lt/eq/gt flags.
module compare_seq
   import compare_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] op0,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [2:0]            relation,
   input  logic                  signed_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] compare_result,
   output logic                  flag_lt,
   output logic                  flag_eq,
   output logic                  flag_gt,
   output logic                  illegal
);

   localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

   cmp_state_e state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [NCHUNK-1:0][CHUNK_WIDTH-1:0] op0_q, op0_d, op1_q, op1_d;
   logic [2:0] relation_q, relation_d;
   logic signed_q, signed_d;
   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic result_q, result_d;
   logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic illegal_q, illegal_d;

   logic chunk_lt, chunk_eq, chunk_gt;

   // Only the most significant chunk carries the sign bit.
   compare_chunk #(.WIDTH(CHUNK_WIDTH)) u_chunk (
      .a         (op0_q[idx_q]),
      .b         (op1_q[idx_q]),
      .signed_en (signed_q && (idx_q == IDX_TOP)),
      .lt        (chunk_lt),
      .eq        (chunk_eq),
      .gt        (chunk_gt)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      op0_d       = op0_q;
      op1_d       = op1_q;
      relation_d  = relation_q;
      signed_d    = signed_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      gt_d        = gt_q;
      illegal_d   = illegal_q;
      case (state_q)
         CMP_IDLE: begin
            if (in_valid) begin
               op0_d      = op0;
               op1_d      = op1;
               relation_d = relation;
               signed_d   = signed_mode;
               idx_d      = IDX_TOP;
               in_ready_d = 1'b0;
               if (relation_illegal(relation)) begin
                  state_d     = CMP_DONE;
                  out_valid_d = 1'b1;
                  illegal_d   = 1'b1;
                  result_d    = 1'b0;
                  lt_d        = 1'b0;
                  eq_d        = 1'b0;
                  gt_d        = 1'b0;
               end else begin
                  state_d = CMP_SCAN;
               end
            end
         end
         CMP_SCAN: begin
            if (!chunk_eq || (idx_q == '0)) begin
               state_d     = CMP_DONE;
               out_valid_d = 1'b1;
               illegal_d   = 1'b0;
               lt_d        = chunk_lt;
               eq_d        = chunk_eq;
               gt_d        = chunk_gt;
               result_d    = relation_result(relation_q, chunk_lt, chunk_eq, chunk_gt);
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         CMP_DONE: begin
            if (out_ready) begin
               state_d     = CMP_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = CMP_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // Operand registers carry no reset value; they are always reloaded on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CMP_IDLE;
         idx_q       <= IDX_TOP;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         op0_q       <= op0_d;
         op1_q       <= op1_d;
         relation_q  <= relation_d;
         signed_q    <= signed_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
         illegal_q   <= illegal_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign compare_result = {{(DATA_WIDTH-1){1'b0}}, result_q};
   assign flag_lt        = lt_q;
   assign flag_eq        = eq_q;
   assign flag_gt        = gt_q;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq (32-bit operands, 8-bit chunks): table of
// hand-computed vectors plus backpressure, mid-scan reset and reset/request races.
module tb_compare_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op0;
   logic [31:0] op1;
   logic [2:0]  relation;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] compare_result;
   logic        flag_lt;
   logic        flag_eq;
   logic        flag_gt;
   logic        illegal;

   int compared;
   int mismatched;

   typedef struct packed {
      logic [31:0] op0;
      logic [31:0] op1;
      logic [2:0]  rel;
      logic        sgn;
      logic        res;
      logic        lt;
      logic        eq;
      logic        gt;
      logic        ill;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs [12];

   compare_seq #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .op0            (op0),
      .op1            (op1),
      .relation       (relation),
      .signed_mode    (signed_mode),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .compare_result (compare_result),
      .flag_lt        (flag_lt),
      .flag_eq        (flag_eq),
      .flag_gt        (flag_gt),
      .illegal        (illegal)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Issues one request, scrambles the inputs while busy, and returns the
   // number of cycles from the accept edge until out_valid (capped).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] rel, input logic sgn,
                                output int latency);
      op0         = a;
      op1         = b;
      relation    = rel;
      signed_mode = sgn;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      op0         = $urandom;
      op1         = $urandom;
      relation    = 3'($urandom_range(0, 7));
      signed_mode = 1'($urandom_range(0, 1));
      latency     = 1;
      while (!out_valid && latency < 20) begin
         @(posedge clk);
         #1;
         latency++;
      end
   endtask

   task automatic releaseOutput();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic checkResult(input string tag, input vec_t v, input int latency);
      checkOutput({tag, "_latency"}, 32'(latency), 32'(v.lat));
      checkOutput({tag, "_result"}, compare_result, {31'd0, v.res});
      checkOutput({tag, "_lt"}, {31'd0, flag_lt}, {31'd0, v.lt});
      checkOutput({tag, "_eq"}, {31'd0, flag_eq}, {31'd0, v.eq});
      checkOutput({tag, "_gt"}, {31'd0, flag_gt}, {31'd0, v.gt});
      checkOutput({tag, "_illegal"}, {31'd0, illegal}, {31'd0, v.ill});
   endtask

   initial begin
      int   lat;
      logic seen_valid;
      vec_t v;

      compared    = 0;
      mismatched  = 0;
      clk         = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      op0         = '0;
      op1         = '0;
      relation    = 3'd0;
      signed_mode = 1'b0;

      //            op0           op1           rel  sgn res lt eq gt ill lat
      vecs[0]  = '{32'h12345678, 32'h12345679, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
      vecs[1]  = '{32'h80000000, 32'h00000001, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
      vecs[2]  = '{32'h80000000, 32'h00000001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
      vecs[3]  = '{32'hDEADBEEF, 32'hDEADBEEF, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
      vecs[4]  = '{32'hDEADBEEF, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
      vecs[5]  = '{32'h00000001, 32'h00000002, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[6]  = '{32'h00000080, 32'h0000007F, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
      vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFF00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
      vecs[8]  = '{32'h7F000000, 32'h80000000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
      vecs[9]  = '{32'h00010000, 32'h00020000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
      vecs[10] = '{32'h55555555, 32'h55555555, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[11] = '{32'h12340000, 32'h12350000, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_result", compare_result, 32'd0);
      checkOutput("reset_flags", {28'd0, flag_lt, flag_eq, flag_gt, illegal}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         applyStimulus(vecs[i].op0, vecs[i].op1, vecs[i].rel, vecs[i].sgn, lat);
         checkResult($sformatf("v%0d", i), vecs[i], lat);
         releaseOutput();
      end

      // Backpressure: outputs hold while the consumer stalls.
      v = '{32'h00000005, 32'h00000003, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
      applyStimulus(v.op0, v.op1, v.rel, v.sgn, lat);
      checkResult("bp", v, lat);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
         checkOutput($sformatf("bp_hold%0d_result", c), compare_result, 32'd1);
         checkOutput($sformatf("bp_hold%0d_flags", c), {29'd0, flag_lt, flag_eq, flag_gt}, 32'd1);
         checkOutput($sformatf("bp_hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      end
      releaseOutput();
      checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      v = '{32'h00000003, 32'h00000005, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
      applyStimulus(v.op0, v.op1, v.rel, v.sgn, lat);
      checkResult("bp_next", v, lat);
      releaseOutput();

      // Reset during the second scan cycle discards the request.
      op0         = 32'h12345678;
      op1         = 32'h12345679;
      relation    = 3'd1;
      signed_mode = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_mid_result", compare_result, 32'd0);
      checkOutput("rst_mid_flags", {28'd0, flag_lt, flag_eq, flag_gt, illegal}, 32'd0);
      seen_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid = 1'b1;
      end
      checkOutput("rst_mid_no_spurious_valid", {31'd0, seen_valid}, 32'd0);

      // Reset and request in the same cycle: the request is dropped.
      op0         = 32'h00000001;
      op1         = 32'h00000002;
      relation    = 3'd7;
      rst         = 1'b1;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("rst_race_in_ready", {31'd0, in_ready}, 32'd1);
      seen_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid = 1'b1;
      end
      checkOutput("rst_race_no_valid", {31'd0, seen_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
